// File: rtl/text_overlay_gen_pkg.sv
// Shared constants and types for the multi-row text overlay.
`timescale 1ns/1ps
package text_overlay_pkg;
  localparam int FONT_W      = 8;
  localparam int FONT_H      = 16;
  localparam int CHAR_W      = 7;
  localparam int FONT_ADDR_W = 11;
  localparam int LATENCY     = 3;

  localparam logic [CHAR_W-1:0] SPACE_CHAR = 7'h20;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
endpackage

// File: rtl/text_overlay_gen_font_rom.sv
// 8x16 glyph ROM with a registered read: 11-bit address {char, glyph_row}, MSB = leftmost pixel.
`timescale 1ns/1ps
module font_rom (
  input  logic        i_clk,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);
  logic [127:0] w_glyph;

  // Each glyph is 16 rows packed with row 0 in the top byte.
  always_comb begin
    w_glyph = 128'h0000_7E42_4242_4242_4242_7E00_0000_0000;
    case (i_addr[10:4])
      7'h20:   w_glyph = 128'h0;
      7'h41:   w_glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h5A:   w_glyph = 128'h0000_FEC6_8C18_3060_C2C6_FE00_0000_0000;
      default: w_glyph = 128'h0000_7E42_4242_4242_4242_7E00_0000_0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    o_data <= w_glyph[{~i_addr[3:0], 3'b000} +: 8];
  end
endmodule

// File: rtl/text_overlay_gen.sv
// Writable COLSxROWS character overlay rendered through font_rom, with blinking
// inverse cursor and a power-on buffer clear; 3-cycle pixel pipeline.
`timescale 1ns/1ps
module text_overlay_gen
  import text_overlay_pkg::*;
#(
  parameter int          X0         = 320,
  parameter int          Y0         = 292,
  parameter int          COLS       = 17,
  parameter int          ROWS       = 2,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [2:0]  FG_RGB     = 3'b111,
  parameter logic [2:0]  BG_RGB     = 3'b000,
  parameter int          BLINK_LOG2 = 4,
  localparam int         DEPTH      = COLS * ROWS,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic              i_f_clock,
  input  logic              i_reset,
  input  logic              i_f_on,
  input  logic [9:0]        i_f_row,
  input  logic [10:0]       i_f_column,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [CHAR_W-1:0] i_wr_char,
  input  logic              i_cursor_en,
  input  logic [AW-1:0]     i_cursor_addr,
  output logic              o_busy,
  output logic              o_r_out,
  output logic              o_g_out,
  output logic              o_b_out
);
  localparam int X_END = X0 + COLS * FONT_W * (1 << SCALE_LOG2);
  localparam int Y_END = Y0 + ROWS * FONT_H * (1 << SCALE_LOG2);

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_clr_cnt, w_clr_cnt_nxt;
  logic                w_we;
  logic [AW-1:0]       w_wr_addr;
  logic [CHAR_W-1:0]   w_wr_data;
  logic [CHAR_W-1:0]   r_mem [DEPTH];
  logic [7:0]          r_frame_cnt;

  logic [10:0]         w_pix_x, w_pix_y, w_dx, w_dy, w_col, w_row;
  logic [2:0]          w_dx_s;
  logic [3:0]          w_glyph_row;
  logic                w_in_region, w_vis, w_inverse, w_px, w_unused;
  logic [AW-1:0]       w_cell, w_rd_addr;

  logic [CHAR_W-1:0]   r_s1_char;
  logic                r_s1_vis, r_s1_inv, r_s2_vis, r_s2_inv;
  logic [3:0]          r_s1_grow;
  logic [2:0]          r_s1_bit, r_s2_bit;
  logic [FONT_ADDR_W-1:0] w_font_addr;
  logic [7:0]          w_font_data;
  logic [2:0]          r_rgb;

  assign o_busy   = (r_state == ST_CLEAR);
  assign w_unused = i_f_column[10];

  always_ff @(posedge i_f_clock) begin
    if (i_reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // The clear sequence owns the write port; host writes only land in IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we          = 1'b0;
    w_wr_addr     = i_wr_addr;
    w_wr_data     = i_wr_char;
    case (r_state)
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_wr_addr = r_clr_cnt;
        w_wr_data = SPACE_CHAR;
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + AW'(1);
        end
      end
      ST_IDLE: begin
        w_we = i_wr_en && ({1'b0, i_wr_addr} < (AW + 1)'(DEPTH));
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_pix_x     = {1'b0, i_f_column[9:0]};
  assign w_pix_y     = {1'b0, i_f_row};
  assign w_dx        = w_pix_x - 11'(X0);
  assign w_dy        = w_pix_y - 11'(Y0);
  assign w_in_region = (w_pix_x >= 11'(X0)) && (w_pix_x < 11'(X_END)) &&
                       (w_pix_y >= 11'(Y0)) && (w_pix_y < 11'(Y_END));
  assign w_col       = w_dx >> (3 + SCALE_LOG2);
  assign w_row       = w_dy >> (4 + SCALE_LOG2);
  assign w_cell      = AW'(w_row * 11'(COLS) + w_col);
  assign w_rd_addr   = w_in_region ? w_cell : '0;
  assign w_dx_s      = 3'(w_dx >> SCALE_LOG2);
  assign w_glyph_row = 4'(w_dy >> SCALE_LOG2);
  assign w_vis       = i_f_on && w_in_region && !o_busy;
  assign w_inverse   = i_cursor_en && (w_rd_addr == i_cursor_addr) &&
                       r_frame_cnt[BLINK_LOG2];

  // Read-first RAM: a same-cycle write to the rendered cell returns the old code.
  always_ff @(posedge i_f_clock) begin
    if (w_we) r_mem[w_wr_addr] <= w_wr_data;
    r_s1_char <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_f_clock) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
    end else if (i_f_row == 10'd0 && i_f_column[9:0] == 10'd0) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_f_clock) begin
    if (i_reset) begin
      r_s1_vis  <= 1'b0;
      r_s1_inv  <= 1'b0;
      r_s1_grow <= '0;
      r_s1_bit  <= '0;
      r_s2_vis  <= 1'b0;
      r_s2_inv  <= 1'b0;
      r_s2_bit  <= '0;
      r_rgb     <= 3'b000;
    end else begin
      r_s1_vis  <= w_vis;
      r_s1_inv  <= w_inverse;
      r_s1_grow <= w_glyph_row;
      r_s1_bit  <= ~w_dx_s;
      r_s2_vis  <= r_s1_vis;
      r_s2_inv  <= r_s1_inv;
      r_s2_bit  <= r_s1_bit;
      r_rgb     <= r_s2_vis ? (w_px ? FG_RGB : BG_RGB) : 3'b000;
    end
  end

  assign w_font_addr = {r_s1_char, r_s1_grow};
  assign w_px        = w_font_data[r_s2_bit] ^ r_s2_inv;

  font_rom u_font_rom (
    .i_clk  (i_f_clock),
    .i_addr (w_font_addr),
    .o_data (w_font_data)
  );

  assign o_r_out = r_rgb[2];
  assign o_g_out = r_rgb[1];
  assign o_b_out = r_rgb[0];
endmodule

// File: doc/text_overlay_gen.md
# text_overlay_gen

Parametrised multi-row text overlay for the VGA pixel path. It holds a writable character buffer of COLS×ROWS ASCII codes and renders them through the 8×16 `font_rom` at a configurable screen origin and integer scale. It adds a blinking inverse-video cursor and a power-on buffer clear. It sits between the VGA sync counter (F_ROW/F_COLUMN/F_ON) and the RGB pins, replacing the fixed single-string generators.

## Interface
- X0, 320: left pixel column of the text region.
- Y0, 292: top pixel row of the text region.
- COLS, 17: characters per row.
- ROWS, 2: text rows.
- SCALE_LOG2, 0: glyph magnification is 2^SCALE_LOG2. Legal range 0..2.
- FG_RGB, 3'b111: foreground colour {R,G,B}.
- BG_RGB, 3'b000: background colour inside the region.
- BLINK_LOG2, 4: cursor toggles every 2^BLINK_LOG2 frames.
- F_CLOCK  in  1  pixel clock. All logic runs on its rising edge.
- RESET  in  1  synchronous, active-high.
- F_ON  in  1  visible-area flag from the sync generator.
- F_ROW  in  10  current pixel row.
- F_COLUMN  in  11  current pixel column. Only bits [9:0] are used.
- WR_EN  in  1  write strobe for the character buffer.
- WR_ADDR  in  AW=$clog2(COLS*ROWS)  cell index, computed as row*COLS+col.
- WR_CHAR  in  7  ASCII code to write.
- CURSOR_EN  in  1  enables the cursor.
- CURSOR_ADDR  in  AW  cursor cell index.
- BUSY  out  1  high while the clear sequence runs.
- R_OUT, G_OUT, B_OUT  out  1 each  registered colour outputs.

## Operation
- **Control FSM** has two states, CLEAR and IDLE.
  - RESET forces CLEAR with clear counter = 0.
  - In CLEAR, the FSM writes 7'h20 (space) to cell[counter] each cycle and increments the counter.
  - After cell COLS*ROWS−1 it moves to IDLE.
  - BUSY = (state == CLEAR).
  - Host writes are ignored in CLEAR.
  - RESET asserted mid-clear restarts the clear from cell 0.
- **Host writes** (IDLE only): when WR_EN=1 and WR_ADDR < COLS*ROWS, the cell is written on the next edge. Out-of-range addresses are dropped silently.
- **Region test:**
  - dx = pix_x − X0, dy = pix_y − Y0, computed at 11 bits.
  - The pixel is in region when pix_x ≥ X0, pix_x < X0 + COLS·8·2^S, pix_y ≥ Y0 and pix_y < Y0 + ROWS·16·2^S.
- **Cell and glyph indexing:**
  - col = dx >> (3+S), row = dy >> (4+S).
  - glyph_row = (dy >> S)[3:0], bit = 7 − (dx >> S)[2:0].
  - Bit 7 of the font word is the leftmost pixel.
- **Font address** = {char[6:0], glyph_row[3:0]}, 11 bits.
- **Frame counter:** an 8-bit counter that increments once per frame, when F_ROW=0 and F_COLUMN=0 are sampled. It wraps 255→0.
  - blink = frame_cnt[BLINK_LOG2].
- **Pixel colour:**
  - The inverse flag is set when CURSOR_EN=1, the cell equals CURSOR_ADDR, and blink=1.
  - px = font_bit XOR inverse.
  - Colour = px ? FG_RGB : BG_RGB.
  - Output is 000 when F_ON=0, when out of region, or while BUSY.
- **Colour mapping:** R_OUT=rgb[2], G_OUT=rgb[1], B_OUT=rgb[0].

## Timing
- **Pipeline:** fixed latency of 3 F_CLOCK cycles from F_ROW/F_COLUMN/F_ON to R/G/B.
  - S1: buffer read at the cell address (registered RAM read). In-region flag, inverse flag, glyph_row, bit index and F_ON are also registered here.
  - S2: font_rom read (registered). The side-band signals are delayed by one more stage.
  - S3: bit select and colour mux into the output registers.
- The sync generator delays HSYNC/VSYNC by 3 cycles to stay aligned.
- **Buffer write/read collision:** a write and a render read of the same cell in the same cycle return the old data (read-first). The new character is visible from the next access.
- **Reset values:** R/G/B=0, BUSY=1 on the first cycle after RESET, frame_cnt=0, all pipeline valid flags=0.
- **Clear duration:** exactly COLS*ROWS cycles after RESET deasserts. BUSY falls on the following edge.
- CURSOR_ADDR and CURSOR_EN are sampled at S1.

## Structure
- Package `text_overlay_pkg` holds:
  - FONT_W=8, FONT_H=16, CHAR_W=7, FONT_ADDR_W=11.
  - the space code 7'h20.
  - LATENCY=3.
  - FSM state enum {ST_CLEAR, ST_IDLE}.
- Sub-module: the existing `font_rom` (8×16 glyphs, 11-bit address, 8-bit data). It is instantiated on F_CLOCK rising edge, not inverted.
- The character buffer is inferred single-port-write/single-port-read RAM in this module.

## Test plan
- **Reset/clear:** pulse RESET with default params → BUSY high for 34 cycles, every pixel 000 meanwhile; afterwards the whole region renders BG (space glyph).
- **Basic glyph:** write 'A' (7'h41) to cell 0, scan row 292+5 → the pixel pattern at columns 320..327 equals font_rom[{41h,5}] MSB-first, appearing 3 cycles after the coordinates.
- **Second row/bounds:** write 'Z' to cell 17 → it appears at x=320..327, y=308..323. Pixels at x=319, x=456 and y=324 are 000.
- **Scale:** SCALE_LOG2=1 → each font bit spans 2×2 pixels. The region ends at x=320+272.
- **Cursor blink:** CURSOR_EN=1, CURSOR_ADDR=3 → cell 3 renders inverted during frames 16–31, normal during frames 0–15 and 32–47.
- **Collisions:** a WR_EN with WR_ADDR=40 (out of range) leaves the buffer unchanged. A write during BUSY is dropped. RESET mid-clear restarts the 34-cycle clear.
